// File: rtl/temp_sensor_reader.sv
// temp_sensor_reader: SPI-style master for a 16-bit serial temperature sensor.
// One Sample_Req produces one frame, decoded into a saturated whole-degree byte
// with a one-cycle Temp_Valid strobe and a Fault flag.
// Optional build macro TEMP_AVG4_EN: outputs a 4-sample moving average of good
// readings, adding one pipeline cycle before Temp_Valid.
module temp_sensor_reader #(
    parameter int CLK_DIV    = 25,
    parameter int FRAME_BITS = 16
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Sample_Req,
    input  logic       Sensor_MISO,
    output logic       Sensor_CS_n,
    output logic       Sensor_SCLK,
    output logic       Busy,
    output logic       Temp_Valid,
    output logic [7:0] Temp_Data,
    output logic       Fault
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(FRAME_BITS);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    // UPDATE already uses one cycle of the CS-high gap, so GAP runs one short.
    localparam logic [CW-1:0] GAP_LAST = CW'(CLK_DIV - 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, UPDATE, GAP} state_t;

    state_t                  state_reg, state_next;
    logic [CW-1:0]           cnt_reg, cnt_next;
    logic [BW-1:0]           bit_reg, bit_next;
    logic [FRAME_BITS-1:0]   shift_reg, shift_next;
    logic                    sclk_reg, sclk_next;
    logic                    cs_n_reg, cs_n_next;
    logic                    busy_reg, busy_next;
    logic                    valid_reg, valid_next;
    logic [7:0]              data_reg, data_next;
    logic                    fault_reg, fault_next;

    // Frame decode: bit 15 must be 0, bit 2 is open-sensor, bits 14:5 are whole degrees.
    logic       frame_fault;
    logic [9:0] frame_deg;
    logic [7:0] frame_sat;

    assign frame_fault = shift_reg[15] | shift_reg[2];
    assign frame_deg   = shift_reg[14:5];
    assign frame_sat   = (frame_deg > 10'd255) ? 8'hFF : frame_deg[7:0];

`ifdef TEMP_AVG4_EN
    // History holds the three previous good samples; the fourth is the new one.
    logic [7:0] win_reg   [3];
    logic [7:0] win_next  [3];
    logic [7:0] win_shift [3];
    logic       seed_reg, seed_next;
    logic [7:0] samp_data_reg, samp_data_next;
    logic       samp_fault_reg, samp_fault_next;
    logic [9:0] win_sum;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_win
            if (gi == 0) begin : g_head
                assign win_shift[gi] = samp_data_reg;
            end else begin : g_tail
                assign win_shift[gi] = win_reg[gi-1];
            end
        end
    endgenerate
`endif

    // Next-state, SPI timing and result update logic.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 1'b1;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        sclk_next  = sclk_reg;
        valid_next = 1'b0;
        data_next  = data_reg;
        fault_next = fault_reg;
`ifdef TEMP_AVG4_EN
        win_next        = win_reg;
        seed_next       = seed_reg;
        samp_data_next  = samp_data_reg;
        samp_fault_next = samp_fault_reg;
        win_sum         = 10'(samp_data_reg);
        for (int i = 0; i < 3; i++) begin
            win_sum = win_sum + 10'(seed_reg ? samp_data_reg : win_reg[i]);
        end
`endif
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (Sample_Req) begin
                    state_next = SETUP;
                    bit_next   = '0;
                end
            end
            SETUP: begin
                if (cnt_reg == DIV_LAST) begin
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_reg == DIV_LAST) begin
                    cnt_next = '0;
                    if (!sclk_reg) begin
                        // MISO is captured on the same edge SCLK rises.
                        sclk_next  = 1'b1;
                        shift_next = {shift_reg[FRAME_BITS-2:0], Sensor_MISO};
                    end else begin
                        sclk_next = 1'b0;
                        if (bit_reg == BIT_LAST) begin
                            state_next = HOLD;
                        end else begin
                            bit_next = bit_reg + 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (cnt_reg == DIV_LAST) begin
                    cnt_next   = '0;
                    state_next = UPDATE;
`ifdef TEMP_AVG4_EN
                    samp_data_next  = frame_sat;
                    samp_fault_next = frame_fault;
`else
                    valid_next = 1'b1;
                    fault_next = frame_fault;
                    data_next  = frame_fault ? 8'hFF : frame_sat;
`endif
                end
            end
            UPDATE: begin
                cnt_next   = '0;
                state_next = GAP;
`ifdef TEMP_AVG4_EN
                valid_next = 1'b1;
                if (samp_fault_reg) begin
                    // Fault frames never enter the window and force a reseed.
                    fault_next = 1'b1;
                    data_next  = 8'hFF;
                    seed_next  = 1'b1;
                end else begin
                    fault_next = 1'b0;
                    data_next  = win_sum[9:2];
                    seed_next  = 1'b0;
                    for (int i = 0; i < 3; i++) begin
                        win_next[i] = seed_reg ? samp_data_reg : win_shift[i];
                    end
                end
`endif
            end
            GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    cnt_next = '0;
                    // A request pending at the end of the gap starts the next
                    // frame directly, keeping CS_n high exactly CLK_DIV cycles.
                    if (Sample_Req) begin
                        state_next = SETUP;
                        bit_next   = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
        cs_n_next = !(state_next == SETUP || state_next == SHIFT || state_next == HOLD);
        busy_next = (state_next != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            sclk_reg  <= 1'b0;
            cs_n_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            valid_reg <= 1'b0;
            data_reg  <= 8'h00;
            fault_reg <= 1'b0;
`ifdef TEMP_AVG4_EN
            for (int i = 0; i < 3; i++) begin
                win_reg[i] <= 8'h00;
            end
            seed_reg       <= 1'b1;
            samp_data_reg  <= 8'h00;
            samp_fault_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            sclk_reg  <= sclk_next;
            cs_n_reg  <= cs_n_next;
            busy_reg  <= busy_next;
            valid_reg <= valid_next;
            data_reg  <= data_next;
            fault_reg <= fault_next;
`ifdef TEMP_AVG4_EN
            win_reg        <= win_next;
            seed_reg       <= seed_next;
            samp_data_reg  <= samp_data_next;
            samp_fault_reg <= samp_fault_next;
`endif
        end
    end

    assign Sensor_CS_n = cs_n_reg;
    assign Sensor_SCLK = sclk_reg;
    assign Busy        = busy_reg;
    assign Temp_Valid  = valid_reg;
    assign Temp_Data   = data_reg;
    assign Fault       = fault_reg;

endmodule

// File: tb/tb_temp_sensor_reader.sv
// Testbench for temp_sensor_reader: directed and random sensor frames checked
// against an arithmetic reference model (honours TEMP_AVG4_EN when defined).
module tb_temp_sensor_reader;

    localparam int D = 25;
`ifdef TEMP_AVG4_EN
    localparam int AVG = 1;
`else
    localparam int AVG = 0;
`endif

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Sample_Req;
    logic       Sensor_MISO;
    logic       Sensor_CS_n;
    logic       Sensor_SCLK;
    logic       Busy;
    logic       Temp_Valid;
    logic [7:0] Temp_Data;
    logic       Fault;

    int n_vec  = 0;
    int n_fail = 0;

    logic [15:0] cur_frame = 16'h0000;

    // Reference model state
    int exp_data  = 0;
    int exp_fault = 0;
    int win[$];

    temp_sensor_reader #(.CLK_DIV(D), .FRAME_BITS(16)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Sample_Req  (Sample_Req),
        .Sensor_MISO (Sensor_MISO),
        .Sensor_CS_n (Sensor_CS_n),
        .Sensor_SCLK (Sensor_SCLK),
        .Busy        (Busy),
        .Temp_Valid  (Temp_Valid),
        .Temp_Data   (Temp_Data),
        .Fault       (Fault)
    );

    always #5 Clock = ~Clock;

    // Sensor model: MSB presented while CS_n is high, next bit after each SCLK fall.
    initial begin
        int idx;
        logic prev_sclk;
        idx = 15;
        prev_sclk = 1'b0;
        Sensor_MISO = 1'b0;
        forever begin
            @(posedge Clock);
            #1;
            if (Sensor_CS_n) idx = 15;
            else if (prev_sclk && !Sensor_SCLK && idx > 0) idx = idx - 1;
            Sensor_MISO = cur_frame[idx];
            prev_sclk = Sensor_SCLK;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Expected result of one frame, straight from the decode rules.
    task automatic model_frame(input logic [15:0] f);
        int t, deg, sat, sum;
        bit bad;
        t   = int'(f);
        bad = (t >= 32768) || (((t / 4) % 2) == 1);
        deg = (t % 32768) / 32;
        sat = (deg > 255) ? 255 : deg;
        if (bad) begin
            exp_data  = 255;
            exp_fault = 1;
            win.delete();
        end else begin
            exp_fault = 0;
            if (AVG == 1) begin
                if (win.size() == 0) begin
                    repeat (4) win.push_back(sat);
                end else begin
                    win.push_back(sat);
                    void'(win.pop_front());
                end
                sum = 0;
                foreach (win[i]) sum += win[i];
                exp_data = sum / 4;
            end else begin
                exp_data = sat;
            end
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (n < 2000) begin
            @(posedge Clock); #1;
            n++;
            if (Temp_Valid) break;
        end
    endtask

    task automatic wait_idle(output int m);
        m = 0;
        while (m < 2000) begin
            @(posedge Clock); #1;
            m++;
            if (!Busy) break;
        end
    endtask

    // One complete request; poke>0 pulses Sample_Req that many cycles into the frame.
    task automatic run_frame(input logic [15:0] f, input int poke);
        int n, m, cs_low, rises, extra;
        logic prev;
        cur_frame = f;
        model_frame(f);
        @(negedge Clock); Sample_Req = 1'b1;
        @(posedge Clock); #1; Sample_Req = 1'b0;
        check("cs_low_on_accept", 32'(Sensor_CS_n), 32'd0);
        check("busy_on_accept", 32'(Busy), 32'd1);
        n = 0; cs_low = 1; rises = 0; extra = 0; prev = Sensor_SCLK;
        while (n < 2000) begin
            @(posedge Clock); #1;
            n++;
            if (n == poke) Sample_Req = 1'b1;
            else if (n == poke + 1) Sample_Req = 1'b0;
            if (Temp_Valid) break;
            if (!Sensor_CS_n) cs_low++;
            if (Sensor_SCLK && !prev) rises++;
            prev = Sensor_SCLK;
        end
        check("valid_latency", 32'(n), 32'(34 * D + AVG));
        check("cs_low_cycles", 32'(cs_low), 32'(34 * D));
        check("sclk_pulses", 32'(rises), 32'd16);
        check("temp_data", 32'(Temp_Data), 32'(exp_data));
        check("fault", 32'(Fault), 32'(exp_fault));
        m = 0;
        while (m < 2000) begin
            @(posedge Clock); #1;
            m++;
            if (Temp_Valid) extra++;
            if (!Busy) break;
        end
        check("busy_drop_delay", 32'(m), 32'(D - AVG));
        repeat (D + 3) begin
            @(posedge Clock); #1;
            if (Temp_Valid || !Sensor_CS_n) extra++;
        end
        check("no_extra_activity", 32'(extra), 32'd0);
        check("temp_data_held", 32'(Temp_Data), 32'(exp_data));
        $display("frame %04h poke=%0d -> data=%0d fault=%0d latency=%0d", f, poke, Temp_Data, Fault, n);
    endtask

    initial begin
        int n, h, r;
        logic [15:0] f;
        Reset = 1'b1;
        Sample_Req = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        check("rst_cs_n", 32'(Sensor_CS_n), 32'd1);
        check("rst_sclk", 32'(Sensor_SCLK), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_valid", 32'(Temp_Valid), 32'd0);
        check("rst_data", 32'(Temp_Data), 32'd0);
        check("rst_fault", 32'(Fault), 32'd0);
        Reset = 1'b0;
        repeat (2) @(posedge Clock);

        // Directed frames: nominal, saturation, zero, faults, recovery with ignored mid-SHIFT request
        run_frame(16'h0C80, 0);
        run_frame(16'h2580, 0);
        run_frame(16'h0000, 0);
        run_frame(16'h0004, 0);
        run_frame(16'h8C80, 0);
        run_frame(16'h0C80, 300);
        // 100,100,100,200 C, then fault, then 60 C
        run_frame(16'h0C80, 0);
        run_frame(16'h0C80, 0);
        run_frame(16'h1900, 0);
        run_frame(16'h0004, 0);
        run_frame(16'h0780, 0);

        // Back-to-back frames with Sample_Req held high
        cur_frame = 16'h0C80;
        model_frame(16'h0C80);
        @(negedge Clock); Sample_Req = 1'b1;
        @(posedge Clock); #1;
        wait_valid(n);
        check("b2b_first_latency", 32'(n), 32'(34 * D + AVG));
        check("b2b_first_data", 32'(Temp_Data), 32'(exp_data));
        cur_frame = 16'h1900;
        h = 1;
        while (h < 2000) begin
            @(posedge Clock); #1;
            if (!Sensor_CS_n) break;
            h++;
        end
        Sample_Req = 1'b0;
        check("b2b_cs_high_gap", 32'(h), 32'(D - AVG));
        check("b2b_busy_stays", 32'(Busy), 32'd1);
        model_frame(16'h1900);
        wait_valid(n);
        check("b2b_second_latency", 32'(n), 32'(34 * D + AVG));
        check("b2b_second_data", 32'(Temp_Data), 32'(exp_data));
        wait_idle(n);
        check("b2b_idle", 32'(Busy), 32'd0);
        $display("back-to-back frames 0c80,1900 -> gap=%0d data=%0d", h, Temp_Data);

        // Reset during bit 7 of SHIFT
        cur_frame = 16'h0C80;
        @(negedge Clock); Sample_Req = 1'b1;
        @(posedge Clock); #1; Sample_Req = 1'b0;
        r = 0; n = 0;
        begin
            logic prev;
            prev = Sensor_SCLK;
            while (n < 2000 && r < 8) begin
                @(posedge Clock); #1;
                n++;
                if (Sensor_SCLK && !prev) r++;
                prev = Sensor_SCLK;
            end
        end
        check("rst_mid_reached_bit7", 32'(r), 32'd8);
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        exp_data = 0; exp_fault = 0; win.delete();
        check("abort_cs_n", 32'(Sensor_CS_n), 32'd1);
        check("abort_sclk", 32'(Sensor_SCLK), 32'd0);
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_data", 32'(Temp_Data), 32'd0);
        check("abort_fault", 32'(Fault), 32'd0);
        h = 0;
        repeat (2 * D) begin
            @(posedge Clock); #1;
            if (Temp_Valid || !Sensor_CS_n) h++;
        end
        check("abort_quiet", 32'(h), 32'd0);
        $display("reset mid-frame after %0d SCLK pulses -> aborted", r);
        run_frame(16'h0C80, 0);

        // Randomized frames
        for (int i = 0; i < 16; i++) begin
            r = int'($urandom_range(0, 3));
            case (r)
                0: f = 16'($urandom);
                1: f = {1'b0, 12'($urandom), 1'b0, 2'($urandom)};
                2: f = {1'b0, 2'b00, 10'($urandom_range(0, 1023)), 1'b0, 2'($urandom)};
                default: f = {1'($urandom), 12'($urandom), 1'b1, 2'($urandom)};
            endcase
            run_frame(f, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 800)) : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
